// File: rtl/alu_seq.sv
// Multi-cycle ALU for the MIPS EX stage. Single-cycle ops take one cycle through a capture register.
// multu and divu iterate one bit per cycle and write the HI/LO registers.
module alu_seq #(
   parameter int  WIDTH = 32,
   localparam int SH_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             out_valid,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_DIVU  = 4'b1001;
   localparam logic [3:0] OP_MFHI  = 4'b1010;
   localparam logic [3:0] OP_MFLO  = 4'b1011;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t           state_q, state_d;
   logic [SH_W:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             pend_q, pend_d;
   logic [3:0]       pop_q, pop_d;
   logic [WIDTH-1:0] pa_q, pa_d;
   logic [WIDTH-1:0] pb_q, pb_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zero_q, zero_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Shift-add step: {acc_hi, acc_lo} is the partial product, acc_lo shifts the multiplier out.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
   // Restoring step: acc_hi is the remainder, acc_lo shifts the dividend out and the quotient in.
   logic [WIDTH:0]   div_trial;
   logic             div_ge;
   logic [WIDTH-1:0] div_hi_nx, div_lo_nx;
   logic [WIDTH-1:0] pres;

   assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_hi_nx = mul_sum[WIDTH:1];
   assign mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

   assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
   assign div_ge    = ~div_trial[WIDTH];
   assign div_hi_nx = div_ge ? div_trial[WIDTH-1:0] : {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
   assign div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ge};

   always_comb begin
      pres = '0;
      case (pop_q)
         OP_AND:  pres = pa_q & pb_q;
         OP_OR:   pres = pa_q | pb_q;
         OP_ADD:  pres = pa_q + pb_q;
         OP_SLL:  pres = pb_q << pa_q[SH_W-1:0];
         OP_SUB:  pres = pa_q - pb_q;
         OP_SLT:  pres = {{(WIDTH-1){1'b0}}, ($signed(pa_q) < $signed(pb_q))};
         OP_MFHI: pres = hi_q;
         OP_MFLO: pres = lo_q;
         OP_DIVU: pres = '1;
         default: pres = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      opnd_d      = opnd_q;
      pend_d      = 1'b0;
      pop_d       = pop_q;
      pa_d        = pa_q;
      pb_d        = pb_q;
      out_d       = out_q;
      zero_d      = zero_q;
      out_valid_d = 1'b0;
      hi_d        = hi_q;
      lo_d        = lo_q;

      // A pending divu can only be the divide-by-zero case; real divides go straight to DIV.
      if (pend_q) begin
         out_d       = pres;
         zero_d      = (pres == '0);
         out_valid_d = 1'b1;
         if (pop_q == OP_DIVU) begin
            hi_d = pa_q;
            lo_d = '1;
         end
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (op == OP_MULTU || (op == OP_DIVU && in2 != '0)) begin
                  state_d  = (op == OP_MULTU) ? MUL : DIV;
                  cnt_d    = (SH_W+1)'(WIDTH);
                  acc_hi_d = '0;
                  acc_lo_d = in1;
                  opnd_d   = in2;
               end else begin
                  pend_d = 1'b1;
                  pop_d  = op;
                  pa_d   = in1;
                  pb_d   = in2;
               end
            end
         end
         MUL, DIV: begin
            acc_hi_d = (state_q == MUL) ? mul_hi_nx : div_hi_nx;
            acc_lo_d = (state_q == MUL) ? mul_lo_nx : div_lo_nx;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_d == '0) begin
               state_d     = IDLE;
               hi_d        = acc_hi_d;
               lo_d        = acc_lo_d;
               out_d       = acc_lo_d;
               zero_d      = (acc_lo_d == '0);
               out_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         opnd_q      <= '0;
         pend_q      <= 1'b0;
         pop_q       <= '0;
         pa_q        <= '0;
         pb_q        <= '0;
         out_q       <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         opnd_q      <= opnd_d;
         pend_q      <= pend_d;
         pop_q       <= pop_d;
         pa_q        <= pa_d;
         pb_q        <= pb_d;
         out_q       <= out_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out       = out_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, back-to-back, reset-abort and WIDTH=8 sequences,
// then random ops checked against an arithmetic reference model.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  op_s;
   logic [31:0] in1, in2;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out;
   logic        zero, out_valid;
   logic [31:0] hi, lo;

   logic [3:0]  op8;
   logic [7:0]  a8, b8;
   logic        v8, rdy8;
   logic [7:0]  out8;
   logic        zero8, ov8;
   logic [7:0]  hi8, lo8;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(rst), .op(op_s), .in1(in1), .in2(in2), .in_valid(in_valid),
      .in_ready(in_ready), .out(out), .zero(zero), .out_valid(out_valid), .hi(hi), .lo(lo)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst), .op(op8), .in1(a8), .in2(b8), .in_valid(v8),
      .in_ready(rdy8), .out(out8), .zero(zero8), .out_valid(ov8), .hi(hi8), .lo(lo8)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, eout;
      logic        ezero;
      logic [31:0] ehi, elo;
      int          elat;
   } vec_t;

   vec_t tbl [17];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: results straight from integer arithmetic.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eo, output int lat);
      logic [63:0] prod;
      logic [4:0]  sh;
      lat = 1;
      eo  = 32'd0;
      sh  = a[4:0];
      case (op)
         4'd0:  eo = a & b;
         4'd1:  eo = a | b;
         4'd2:  eo = a + b;
         4'd4:  eo = b << sh;
         4'd6:  eo = a - b;
         4'd7:  eo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd10: eo = m_hi;
         4'd11: eo = m_lo;
         4'd8: begin
            prod = {32'd0, a} * {32'd0, b};
            m_hi = prod[63:32];
            m_lo = prod[31:0];
            eo   = m_lo;
            lat  = 32;
         end
         4'd9: begin
            if (b == 32'd0) begin
               m_hi = a;
               m_lo = 32'hFFFF_FFFF;
            end else begin
               m_hi = a % b;
               m_lo = a / b;
               lat  = 32;
            end
            eo = m_lo;
         end
         default: eo = 32'd0;
      endcase
   endtask

   // Issue one op on the 32-bit DUT, wait (bounded) for its result, report what was seen.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] ao, output logic az, output logic [31:0] ahi,
                        output logic [31:0] alo, output int lat, output int rlow);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      op_s = op; in1 = a; in2 = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat  = 0;
      rlow = in_ready ? 0 : 1;
      while (lat < 100) begin
         @(posedge clk);
         #1 lat++;
         if (out_valid) break;
         if (!in_ready) rlow++;
      end
      ao = out; az = zero; ahi = hi; alo = lo;
   endtask

   initial begin
      logic [31:0] ao, ahi, alo, eo, ra, rb;
      logic        az;
      logic [3:0]  rop;
      int          lat, rlow, elat, pulses, acc_cnt, mul_cyc, add_cyc;
      logic        rdy_prev, acc_pend;
      logic [3:0]  bb_op [4];
      logic [31:0] bb_a [4], bb_b [4], bb_e [4];

      tbl[0]  = '{4'd2,  32'd7,          32'd9,          32'd16,         1'b0, 32'd0,          32'd0,          1};
      tbl[1]  = '{4'd6,  32'd5,          32'd5,          32'd0,          1'b1, 32'd0,          32'd0,          1};
      tbl[2]  = '{4'd7,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 32'd0,          32'd0,          1};
      tbl[3]  = '{4'd4,  32'd4,          32'd1,          32'h10,         1'b0, 32'd0,          32'd0,          1};
      tbl[4]  = '{4'd0,  32'hF0F0,       32'hFF00,       32'hF000,       1'b0, 32'd0,          32'd0,          1};
      tbl[5]  = '{4'd1,  32'hF0,         32'h0F,         32'hFF,         1'b0, 32'd0,          32'd0,          1};
      tbl[6]  = '{4'd3,  32'd5,          32'd6,          32'd0,          1'b1, 32'd0,          32'd0,          1};
      tbl[7]  = '{4'd8,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFE,  32'd1,          32};
      tbl[8]  = '{4'd9,  32'd100,        32'd7,          32'd14,         1'b0, 32'd2,          32'd14,         32};
      tbl[9]  = '{4'd10, 32'd0,          32'd0,          32'd2,          1'b0, 32'd2,          32'd14,         1};
      tbl[10] = '{4'd11, 32'd0,          32'd0,          32'd14,         1'b0, 32'd2,          32'd14,         1};
      tbl[11] = '{4'd9,  32'd123,        32'd0,          32'hFFFF_FFFF,  1'b0, 32'd123,        32'hFFFF_FFFF,  1};
      tbl[12] = '{4'd4,  32'd36,         32'd3,          32'h30,         1'b0, 32'd123,        32'hFFFF_FFFF,  1};
      tbl[13] = '{4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 32'd123,        32'hFFFF_FFFF,  1};
      tbl[14] = '{4'd7,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 32'd123,        32'hFFFF_FFFF,  1};
      tbl[15] = '{4'd15, 32'd9,          32'd9,          32'd0,          1'b1, 32'd123,        32'hFFFF_FFFF,  1};
      tbl[16] = '{4'd8,  32'h1_0000,     32'h1_0000,     32'd0,          1'b1, 32'd1,          32'd0,          32};

      bb_op = '{4'd2, 4'd6, 4'd7, 4'd4};
      bb_a  = '{32'd7, 32'd5, 32'hFFFF_FFFF, 32'd4};
      bb_b  = '{32'd9, 32'd5, 32'd1, 32'd1};
      bb_e  = '{32'd16, 32'd0, 32'd1, 32'h10};

      rst = 1'b1; in_valid = 1'b0; op_s = 4'd0; in1 = 32'd0; in2 = 32'd0;
      v8 = 1'b0; op8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
      m_hi = 32'd0; m_lo = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset out", {32'd0, out}, 64'd0);
      check("reset zero", {63'd0, zero}, 64'd1);
      check("reset out_valid", {63'd0, out_valid}, 64'd0);
      check("reset hi/lo", {hi, lo}, 64'd0);
      check("reset in_ready", {63'd0, in_ready}, 64'd1);
      check("reset zero w8", {63'd0, zero8}, 64'd1);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, ao, az, ahi, alo, lat, rlow);
         $display("vec %0d op=%0d a=%0h b=%0h -> out=%0h zero=%0b hi=%0h lo=%0h lat=%0d",
                  i, tbl[i].op, tbl[i].a, tbl[i].b, ao, az, ahi, alo, lat);
         check($sformatf("vec%0d out", i), {32'd0, ao}, {32'd0, tbl[i].eout});
         check($sformatf("vec%0d zero", i), {63'd0, az}, {63'd0, tbl[i].ezero});
         check($sformatf("vec%0d hi", i), {32'd0, ahi}, {32'd0, tbl[i].ehi});
         check($sformatf("vec%0d lo", i), {32'd0, alo}, {32'd0, tbl[i].elo});
         check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].elat));
         check($sformatf("vec%0d busy cycles", i), 64'(rlow), 64'((tbl[i].elat == 32) ? 32 : 0));
         m_hi = tbl[i].ehi;
         m_lo = tbl[i].elo;
      end

      // Back-to-back single-cycle ops: one result pulse per cycle, in order.
      @(negedge clk);
      op_s = bb_op[0]; in1 = bb_a[0]; in2 = bb_b[0]; in_valid = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k < 4) begin
            op_s = bb_op[k]; in1 = bb_a[k]; in2 = bb_b[k];
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         $display("b2b %0d out=%0h zero=%0b valid=%0b", k - 1, out, zero, out_valid);
         check($sformatf("b2b%0d valid", k - 1), {63'd0, out_valid}, 64'd1);
         check($sformatf("b2b%0d out", k - 1), {32'd0, out}, {32'd0, bb_e[k-1]});
         check($sformatf("b2b%0d zero", k - 1), {63'd0, zero}, {63'd0, (bb_e[k-1] == 32'd0)});
      end
      @(posedge clk);
      @(negedge clk);
      check("b2b valid drops", {63'd0, out_valid}, 64'd0);

      // Random ops against the model.
      for (int i = 0; i < 150; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         model(rop, ra, rb, eo, elat);
         do_op(rop, ra, rb, ao, az, ahi, alo, lat, rlow);
         $display("rnd %0d op=%0d a=%0h b=%0h -> out=%0h (exp %0h) lat=%0d",
                  i, rop, ra, rb, ao, eo, lat);
         check($sformatf("rnd%0d out", i), {32'd0, ao}, {32'd0, eo});
         check($sformatf("rnd%0d zero", i), {63'd0, az}, {63'd0, (eo == 32'd0)});
         check($sformatf("rnd%0d hi/lo", i), {ahi, alo}, {m_hi, m_lo});
         check($sformatf("rnd%0d latency", i), 64'(lat), 64'(elat));
         check($sformatf("rnd%0d busy cycles", i), 64'(rlow), 64'((elat == 32) ? 32 : 0));
      end

      // Reset five cycles into a multiply: everything clears, no late result pulse.
      @(negedge clk);
      op_s = 4'd8; in1 = 32'd3; in2 = 32'd5; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      $display("abort: out=%0h zero=%0b hi=%0h lo=%0h ready=%0b", out, zero, hi, lo, in_ready);
      check("abort out", {32'd0, out}, 64'd0);
      check("abort zero", {63'd0, zero}, 64'd1);
      check("abort hi/lo", {hi, lo}, 64'd0);
      check("abort in_ready", {63'd0, in_ready}, 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("abort no pulse", 64'(pulses), 64'd0);

      // WIDTH=8: multiply while a second request is held; it is accepted exactly once.
      @(negedge clk);
      op8 = 4'd8; a8 = 8'h80; b8 = 8'h02; v8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op8 = 4'd2; a8 = 8'd1; b8 = 8'd2;
      rdy_prev = rdy8; acc_pend = 1'b1; acc_cnt = 0; pulses = 0; mul_cyc = -1; add_cyc = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         if (acc_pend && rdy_prev) begin
            acc_pend = 1'b0;
            acc_cnt++;
            #1 v8 = 1'b0;
         end
         @(negedge clk);
         if (ov8) begin
            pulses++;
            $display("w8 cycle %0d out=%0h zero=%0b hi=%0h lo=%0h", c, out8, zero8, hi8, lo8);
            if (mul_cyc < 0) begin
               mul_cyc = c;
               check("w8 mul hi", {56'd0, hi8}, 64'h01);
               check("w8 mul lo", {56'd0, lo8}, 64'h00);
               check("w8 mul zero", {63'd0, zero8}, 64'd1);
            end else begin
               add_cyc = c;
               check("w8 add out", {56'd0, out8}, 64'd3);
            end
         end
         rdy_prev = rdy8;
      end
      check("w8 mul latency", 64'(mul_cyc), 64'd8);
      check("w8 add latency", 64'(add_cyc), 64'd10);
      check("w8 accepts", 64'(acc_cnt), 64'd1);
      check("w8 pulses", 64'(pulses), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
